// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: state codes,
// instruction fields, ALU operations, datapath mux selects and trap causes.
package mc_ctrl_pkg;

  // Controller states; codes are visible on state_out.
  typedef enum logic [4:0] {
    S_IF     = 5'b00000,
    S_ID     = 5'b00001,
    S_EX_R   = 5'b00010,
    S_EX_MEM = 5'b00011,
    S_EX_I   = 5'b00100,
    S_EX_LUI = 5'b00101,
    S_EX_BEQ = 5'b00110,
    S_EX_BNE = 5'b00111,
    S_EX_JR  = 5'b01000,
    S_EX_JAL = 5'b01001,
    S_EX_J   = 5'b01010,
    S_MEM_RD = 5'b01011,
    S_MEM_WR = 5'b01100,
    S_WB_R   = 5'b01101,
    S_WB_I   = 5'b01110,
    S_WB_LW  = 5'b01111,
    S_EX_SRL = 5'b10000,
    S_TRAP   = 5'b11111
  } state_t;

  // Where the ALU operation comes from in the current state.
  typedef enum logic [2:0] {
    AC_ADD    = 3'd0,
    AC_SUB    = 3'd1,
    AC_FUNCT  = 3'd2,
    AC_OPCODE = 3'd3,
    AC_SRL    = 3'd4
  } alu_class_t;

  // Opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct codes (inst[5:0]) for R-type
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // PCSource selects
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  // MemtoReg selects
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_LUI    = 2'b10;
  localparam logic [1:0] M2R_PC     = 2'b11;

  // RegDst selects
  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  // States that wait on mio_ready and therefore run the timeout counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_ctrl_v2_alu_decode.sv
// Combinational ALU operation decode from the per-state ALU class and the
// instruction's opcode/funct fields. Unlisted codes fall back to add.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_operation
);

  // Map (class, opcode, funct) to an ALU opcode.
  always_comb begin
    alu_operation = ALU_ADD;
    case (alu_class)
      AC_ADD: alu_operation = ALU_ADD;
      AC_SUB: alu_operation = ALU_SUB;
      AC_SRL: alu_operation = ALU_SRL;
      AC_FUNCT: begin
        case (funct)
          F_ADD:   alu_operation = ALU_ADD;
          F_SUB:   alu_operation = ALU_SUB;
          F_AND:   alu_operation = ALU_AND;
          F_OR:    alu_operation = ALU_OR;
          F_XOR:   alu_operation = ALU_XOR;
          F_NOR:   alu_operation = ALU_NOR;
          F_SLT:   alu_operation = ALU_SLT;
          F_SRL:   alu_operation = ALU_SRL;
          default: alu_operation = ALU_ADD;
        endcase
      end
      AC_OPCODE: begin
        case (opcode)
          OP_ADDI: alu_operation = ALU_ADD;
          OP_ANDI: alu_operation = ALU_AND;
          OP_ORI:  alu_operation = ALU_OR;
          OP_XORI: alu_operation = ALU_XOR;
          OP_SLTI: alu_operation = ALU_SLT;
          default: alu_operation = ALU_ADD;
        endcase
      end
      default: alu_operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_v2.sv
// Multi-cycle MIPS-subset control unit. Sequences fetch/decode/execute/
// memory/write-back, waits on mio_ready with a bounded timeout, and traps on
// illegal opcodes, memory timeouts and (optionally) signed add/sub overflow.
// Outputs are decoded from the registered state; only IRWrite/PCWrite in IF
// depend on mio_ready combinationally.
module mc_ctrl_v2
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT  = 16,
  parameter bit OVF_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mio_ready,
  input  logic        zero,
  input  logic        overflow,
  input  logic [31:0] inst,
  input  logic        trap_clear,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        CPU_MIO,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [4:0]  state_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t      state, state_next;
  logic [1:0]  cause_q, cause_next;
  logic [CW-1:0] wait_cnt;
  logic        timed_out;
  alu_class_t  alu_class;

  logic [5:0]  opcode, funct;
  logic        unused_inst_bits;

  // zero is consumed by the datapath together with PCWriteCond/Branch; the
  // controller only forwards intent, so it is not used in the state logic.
  assign opcode           = inst[31:26];
  assign funct            = inst[5:0];
  assign unused_inst_bits = ^{inst[25:6], zero};

  assign timed_out  = (wait_cnt == CW'(TIMEOUT - 1));
  assign state_out  = state;
  assign trap_cause = cause_q;

  // State and trap-cause registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IF;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
    end
  end

  // Wait counter: cleared on any state change (so on entry to a wait state),
  // counts non-ready cycles while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (is_wait_state(state) && !mio_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Next-state, trap cause and datapath control decode.
  always_comb begin
    state_next  = state;
    cause_next  = cause_q;
    alu_class   = AC_ADD;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    CPU_MIO     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch      = 1'b0;
    RegDst      = RD_RT;
    MemtoReg    = M2R_ALUOUT;
    ALUSrcB     = SRCB_B;
    PCSource    = PCS_ALU;
    trap        = 1'b0;

    case (state)
      S_IF: begin
        MemRead = 1'b1;
        CPU_MIO = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // Ready in the final wait cycle beats the timeout.
        if (mio_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_ID;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_ID: begin
        ALUSrcB = SRCB_IMMSH;
        case (opcode)
          OP_RTYPE: begin
            if (funct == F_SRL)     state_next = S_EX_SRL;
            else if (funct == F_JR) state_next = S_EX_JR;
            else                    state_next = S_EX_R;
          end
          OP_LW, OP_SW:  state_next = S_EX_MEM;
          OP_BEQ:        state_next = S_EX_BEQ;
          OP_BNE:        state_next = S_EX_BNE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:
                         state_next = S_EX_I;
          OP_LUI:        state_next = S_EX_LUI;
          OP_J:          state_next = S_EX_J;
          OP_JAL:        state_next = S_EX_JAL;
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_EX_R: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_B;
        alu_class = AC_FUNCT;
        if (OVF_TRAP && overflow && ((funct == F_ADD) || (funct == F_SUB))) begin
          state_next = S_TRAP;
          cause_next = CAUSE_OVERFLOW;
        end else begin
          state_next = S_WB_R;
        end
      end

      S_EX_SRL: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        alu_class  = AC_SRL;
        state_next = S_WB_R;
      end

      S_EX_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        alu_class = AC_OPCODE;
        if (OVF_TRAP && overflow && (opcode == OP_ADDI)) begin
          state_next = S_TRAP;
          cause_next = CAUSE_OVERFLOW;
        end else begin
          state_next = S_WB_I;
        end
      end

      S_EX_MEM: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        CPU_MIO = 1'b1;
        if (mio_ready) begin
          state_next = S_WB_LW;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        CPU_MIO  = 1'b1;
        if (mio_ready) begin
          state_next = S_IF;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_WB_R: begin
        RegWrite   = 1'b1;
        RegDst     = RD_RD;
        state_next = S_IF;
      end

      S_WB_I: begin
        RegWrite   = 1'b1;
        state_next = S_IF;
      end

      S_WB_LW: begin
        RegWrite   = 1'b1;
        MemtoReg   = M2R_MDR;
        state_next = S_IF;
      end

      S_EX_LUI: begin
        RegWrite   = 1'b1;
        MemtoReg   = M2R_LUI;
        state_next = S_IF;
      end

      S_EX_BEQ: begin
        PCWriteCond = 1'b1;
        Branch      = 1'b1;
        ALUSrcA     = 1'b1;
        PCSource    = PCS_ALUOUT;
        alu_class   = AC_SUB;
        state_next  = S_IF;
      end

      S_EX_BNE: begin
        PCWriteCond = 1'b1;
        ALUSrcA     = 1'b1;
        PCSource    = PCS_ALUOUT;
        alu_class   = AC_SUB;
        state_next  = S_IF;
      end

      S_EX_J: begin
        PCWrite    = 1'b1;
        PCSource   = PCS_JUMP;
        state_next = S_IF;
      end

      S_EX_JAL: begin
        PCWrite    = 1'b1;
        PCSource   = PCS_JUMP;
        RegWrite   = 1'b1;
        RegDst     = RD_R31;
        MemtoReg   = M2R_PC;
        state_next = S_IF;
      end

      S_EX_JR: begin
        PCWrite    = 1'b1;
        PCSource   = PCS_RS;
        state_next = S_IF;
      end

      S_TRAP: begin
        trap = 1'b1;
        if (trap_clear) state_next = S_IF;
      end

      default: state_next = S_IF;
    endcase
  end

  mc_alu_decode u_alu_decode (
    .alu_class     (alu_class),
    .opcode        (opcode),
    .funct         (funct),
    .alu_operation (ALU_operation)
  );

endmodule

// File: tb/tb_mc_ctrl_v2.sv
// Directed bench for mc_ctrl_v2. Inputs change on the falling edge, outputs
// are checked 1 time unit later. A second instance with OVF_TRAP=0 shares the
// inputs and is only checked during the overflow scenario.
module tb_mc_ctrl_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mio_ready, zero, overflow, trap_clear;
  logic [31:0] inst;

  logic MemRead, MemWrite, IorD, CPU_MIO, IRWrite, RegWrite, ALUSrcA;
  logic PCWrite, PCWriteCond, Branch, trap;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource, trap_cause;
  logic [2:0] ALU_operation;
  logic [4:0] state_out;

  logic b_MemRead, b_MemWrite, b_IorD, b_CPU_MIO, b_IRWrite, b_RegWrite, b_ALUSrcA;
  logic b_PCWrite, b_PCWriteCond, b_Branch, b_trap;
  logic [1:0] b_RegDst, b_MemtoReg, b_ALUSrcB, b_PCSource, b_trap_cause;
  logic [2:0] b_ALU_operation;
  logic [4:0] b_state_out;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] I_ADD  = 32'h0000_0020;
  localparam logic [31:0] I_LW   = 32'h8C00_0000;
  localparam logic [31:0] I_SW   = 32'hAC00_0000;
  localparam logic [31:0] I_BEQ  = 32'h1000_0000;
  localparam logic [31:0] I_JAL  = 32'h0C00_0000;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;

  // clock / reset block
  always #5 clk = ~clk;

  mc_ctrl_v2 #(.TIMEOUT(16), .OVF_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .mio_ready(mio_ready), .zero(zero),
    .overflow(overflow), .inst(inst), .trap_clear(trap_clear),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .CPU_MIO(CPU_MIO),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALU_operation(ALU_operation), .trap(trap),
    .trap_cause(trap_cause), .state_out(state_out)
  );

  mc_ctrl_v2 #(.TIMEOUT(16), .OVF_TRAP(1'b0)) dut_nt (
    .clk(clk), .rst(rst), .mio_ready(mio_ready), .zero(zero),
    .overflow(overflow), .inst(inst), .trap_clear(trap_clear),
    .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IorD(b_IorD), .CPU_MIO(b_CPU_MIO),
    .IRWrite(b_IRWrite), .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA),
    .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .Branch(b_Branch),
    .RegDst(b_RegDst), .MemtoReg(b_MemtoReg), .ALUSrcB(b_ALUSrcB),
    .PCSource(b_PCSource), .ALU_operation(b_ALU_operation), .trap(b_trap),
    .trap_cause(b_trap_cause), .state_out(b_state_out)
  );

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: advance one clock, landing on the next falling edge
  task automatic step();
    @(negedge clk);
  endtask

  // driver: fetch with immediate ready then decode; returns at the first EX cycle
  task automatic fetch(input logic [31:0] instr);
    inst = instr; mio_ready = 1'b1; #1;
    chk("fetch_if_state", state_out, 5'b00000);
    chk("fetch_irwrite", IRWrite, 1'b1);
    step(); mio_ready = 1'b0; #1;
    chk("fetch_id_state", state_out, 5'b00001);
    step();
  endtask

  initial begin
    rst = 1'b1; mio_ready = 1'b0; zero = 1'b0; overflow = 1'b0;
    trap_clear = 1'b0; inst = 32'h0;
    repeat (2) step();
    #1;
    // reset state
    chk("rst_state", state_out, 5'b00000);
    chk("rst_memread", MemRead, 1'b1);
    chk("rst_cpu_mio", CPU_MIO, 1'b1);
    chk("rst_alusrcb", ALUSrcB, 2'b01);
    chk("rst_irwrite", IRWrite, 1'b0);
    chk("rst_pcwrite", PCWrite, 1'b0);
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_cause", trap_cause, 2'b00);
    chk("rst_trap", trap, 1'b0);
    rst = 1'b0;

    // add with overflow: trap on the OVF_TRAP=1 instance, WB_R on the other
    inst = I_ADD; mio_ready = 1'b1; #1;
    chk("add_pcwrite", PCWrite, 1'b1);
    step(); mio_ready = 1'b0; #1;
    chk("add_id", state_out, 5'b00001);
    chk("add_id_srcb", ALUSrcB, 2'b11);
    step(); overflow = 1'b1; #1;
    chk("add_exr", state_out, 5'b00010);
    chk("add_exr_aluop", ALU_operation, 3'b010);
    chk("add_exr_srca", ALUSrcA, 1'b1);
    chk("add_exr_srcb", ALUSrcB, 2'b00);
    chk("add_exr_regwrite", RegWrite, 1'b0);
    chk("add_nt_exr", b_state_out, 5'b00010);
    step(); overflow = 1'b0; #1;
    chk("ovf_trap_state", state_out, 5'b11111);
    chk("ovf_trap_out", trap, 1'b1);
    chk("ovf_cause", trap_cause, 2'b01);
    chk("ovf_regwrite", RegWrite, 1'b0);
    chk("nt_wbr_state", b_state_out, 5'b01101);
    chk("nt_wbr_regwrite", b_RegWrite, 1'b1);
    chk("nt_wbr_regdst", b_RegDst, 2'b01);
    step(); #1;
    chk("trap_hold", state_out, 5'b11111);
    trap_clear = 1'b1;
    step(); trap_clear = 1'b0; #1;
    chk("trap_clear_if", state_out, 5'b00000);
    chk("trap_clear_cause", trap_cause, 2'b01);
    chk("trap_clear_trap", trap, 1'b0);

    // lw with 3 wait cycles in IF and 2 in MEM_RD
    inst = I_LW;
    for (int i = 0; i < 3; i++) begin
      mio_ready = 1'b0; #1;
      chk("lw_if_wait", state_out, 5'b00000);
      chk("lw_if_wait_irwrite", IRWrite, 1'b0);
      step();
    end
    mio_ready = 1'b1; #1;
    chk("lw_if4", state_out, 5'b00000);
    chk("lw_if4_irwrite", IRWrite, 1'b1);
    step(); mio_ready = 1'b0; #1;
    chk("lw_id", state_out, 5'b00001);
    step(); #1;
    chk("lw_exmem", state_out, 5'b00011);
    chk("lw_exmem_srcb", ALUSrcB, 2'b10);
    chk("lw_exmem_aluop", ALU_operation, 3'b010);
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      chk("lw_memrd_wait", state_out, 5'b01011);
      chk("lw_memrd_regwrite", RegWrite, 1'b0);
    end
    step(); mio_ready = 1'b1; #1;
    chk("lw_memrd3", state_out, 5'b01011);
    chk("lw_memrd_iord", IorD, 1'b1);
    chk("lw_memrd_memread", MemRead, 1'b1);
    step(); mio_ready = 1'b0; #1;
    chk("lw_wblw", state_out, 5'b01111);
    chk("lw_wblw_regwrite", RegWrite, 1'b1);
    chk("lw_wblw_m2r", MemtoReg, 2'b01);
    step(); #1;
    chk("lw_back_if", state_out, 5'b00000);
    chk("lw_back_if_regwrite", RegWrite, 1'b0);

    // sw with immediate ready
    fetch(I_SW); #1;
    chk("sw_exmem", state_out, 5'b00011);
    step(); mio_ready = 1'b1; #1;
    chk("sw_memwr", state_out, 5'b01100);
    chk("sw_memwrite", MemWrite, 1'b1);
    chk("sw_iord", IorD, 1'b1);
    chk("sw_memread", MemRead, 1'b0);
    step(); mio_ready = 1'b0; #1;
    chk("sw_back_if", state_out, 5'b00000);

    // IF timeout: 16 non-ready cycles then TRAP with cause 10
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_if_wait", state_out, 5'b00000);
      step();
    end
    #1;
    chk("to_trap_state", state_out, 5'b11111);
    chk("to_cause", trap_cause, 2'b10);
    trap_clear = 1'b1;
    step(); trap_clear = 1'b0;

    // ready arriving on the 16th cycle wins; then illegal opcode traps
    inst = I_ILL;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("late_if_wait", state_out, 5'b00000);
      step();
    end
    mio_ready = 1'b1; #1;
    chk("late_if16", state_out, 5'b00000);
    chk("late_if16_irwrite", IRWrite, 1'b1);
    step(); mio_ready = 1'b0; #1;
    chk("late_id", state_out, 5'b00001);
    step(); #1;
    chk("ill_trap_state", state_out, 5'b11111);
    chk("ill_cause", trap_cause, 2'b11);
    trap_clear = 1'b1;
    step(); trap_clear = 1'b0;

    // beq taken
    fetch(I_BEQ); zero = 1'b1; #1;
    chk("beq_state", state_out, 5'b00110);
    chk("beq_pcwritecond", PCWriteCond, 1'b1);
    chk("beq_branch", Branch, 1'b1);
    chk("beq_aluop", ALU_operation, 3'b110);
    chk("beq_pcsource", PCSource, 2'b01);
    step(); zero = 1'b0; #1;
    chk("beq_back_if", state_out, 5'b00000);

    // jal
    fetch(I_JAL); #1;
    chk("jal_state", state_out, 5'b01001);
    chk("jal_regdst", RegDst, 2'b10);
    chk("jal_m2r", MemtoReg, 2'b11);
    chk("jal_pcsource", PCSource, 2'b10);
    chk("jal_pcwrite", PCWrite, 1'b1);
    chk("jal_regwrite", RegWrite, 1'b1);
    step(); #1;
    chk("jal_back_if", state_out, 5'b00000);

    // reset asserted during a MEM_WR wait
    fetch(I_SW);
    step(); #1;
    chk("rstmw_memwr", state_out, 5'b01100);
    chk("rstmw_memwrite_before", MemWrite, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstmw_state", state_out, 5'b00000);
    chk("rstmw_memwrite", MemWrite, 1'b0);
    chk("rstmw_cause", trap_cause, 2'b00);
    step(); rst = 1'b0; #1;
    chk("rstmw_after", state_out, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_v2.md
# mc_ctrl_v2

Parametrised multi-cycle MIPS-subset control unit, the successor to the current multi-cycle controller. It sequences fetch, decode, execute, memory and write-back, and drives every datapath mux and enable. Every memory access now stalls on `mio_ready` with a bounded timeout. Overflow on signed add/sub optionally traps, and illegal opcodes trap. A trap state is recoverable without reset.

## Interface
- `TIMEOUT`, 16: maximum wait cycles for `mio_ready` in IF/MEM_RD/MEM_WR (must be ≥2).
- `OVF_TRAP`, 1: when set, overflow on add/sub/addi suppresses write-back and traps.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high. Clock is `clk`.
- `mio_ready`  in  1  memory/IO access complete this cycle.
- `zero`, `overflow`  in  1  ALU flags, valid in the current cycle.
- `inst`  in  32  instruction register contents.
- `trap_clear`  in  1  leave TRAP and re-fetch.
- `MemRead`, `MemWrite`, `IorD`, `CPU_MIO`, `IRWrite`, `RegWrite`, `ALUSrcA`, `PCWrite`, `PCWriteCond`, `Branch`  out  1  datapath enables/selects.
- `RegDst`, `MemtoReg`, `ALUSrcB`, `PCSource`  out  2  mux selects.
- `ALU_operation`  out  3  ALU opcode.
- `trap`  out  1  high while in TRAP.
- `trap_cause`  out  2  01 overflow, 10 timeout, 11 illegal; 00 after reset.
- `state_out`  out  5  current state code.

## Operation
Selects:
- PCSource: 00 ALU, 01 ALUOut, 10 jump, 11 rs.
- MemtoReg: 00 ALUOut, 01 MDR, 10 lui, 11 PC.
- RegDst: 00 rt, 01 rd, 10 $31.
- ALUSrcB: 00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- ALU ops: add 010, sub 110, and 000, or 001, nor 100, slt 111, srl 101, xor 011.

Asserted outputs per state (anything not listed is 0; ALU op is add unless stated):
- IF 00000: `MemRead`, `CPU_MIO`, ALUSrcB=01; `IRWrite` and `PCWrite` only in the cycle `mio_ready`=1.
- ID 00001: ALUSrcB=11.
- EX_R 00010: ALUSrcA, ALUSrcB=00, ALU op from funct.
- EX_SRL 10000: ALUSrcA, ALUSrcB=10, ALU op srl.
- EX_I 00100: ALUSrcA, ALUSrcB=10, ALU op from opcode.
- EX_MEM 00011: ALUSrcA, ALUSrcB=10.
- MEM_RD 01011: `IorD`, `MemRead`, `CPU_MIO`.
- MEM_WR 01100: `IorD`, `MemWrite`, `CPU_MIO`.
- WB_R 01101: `RegWrite`, RegDst=01.
- WB_I 01110: `RegWrite`.
- WB_LW 01111: `RegWrite`, MemtoReg=01.
- EX_LUI 00101: `RegWrite`, MemtoReg=10.
- EX_BEQ 00110: `PCWriteCond`, `Branch`, ALUSrcA, PCSource=01, ALU op sub.
- EX_BNE 00111: as EX_BEQ with `Branch`=0.
- EX_J 01010: `PCWrite`, PCSource=10.
- EX_JAL 01001: `PCWrite`, PCSource=10, `RegWrite`, RegDst=10, MemtoReg=11.
- EX_JR 01000: `PCWrite`, PCSource=11.
- TRAP 11111: `trap`.

Transitions:
- IF→ID on `mio_ready`.
- ID decodes `inst[31:26]`:
  - 000000 decodes funct: 000010 → EX_SRL, 001000 → EX_JR, otherwise EX_R.
  - 100011/101011 → EX_MEM.
  - 000100 → EX_BEQ, 000101 → EX_BNE.
  - 001000/001100/001101/001110/001010 → EX_I.
  - 001111 → EX_LUI.
  - 000010 → EX_J, 000011 → EX_JAL.
  - Any other opcode → TRAP, cause 11.
- EX_MEM: lw → MEM_RD, sw → MEM_WR.
- MEM_RD→WB_LW on ready.
- MEM_WR→IF on ready.
- EX_R/EX_SRL→WB_R.
- EX_I→WB_I.
- Remaining EX and WB states → IF.
- Overflow trap: when `OVF_TRAP`=1 and `overflow`=1 in EX_R (funct add 100000 or sub 100010) or EX_I (addi), go to TRAP with cause 01; no WB state is entered.
- Timeout: a wait counter of width clog2(TIMEOUT+1) clears on entry to IF/MEM_RD/MEM_WR and increments each non-ready cycle. If the counter reaches TIMEOUT-1 with `mio_ready`=0, go to TRAP with cause 10. `mio_ready` in that same cycle wins over the timeout.
- TRAP: holds until `trap_clear`, then goes to IF. `trap_cause` holds until the next trap or reset.
- ALU op for unlisted funct/opcode defaults to add.

## Timing
- Reset: state IF, counter 0, `trap_cause` 00. Outputs immediately show the IF values (`MemRead`=1, `CPU_MIO`=1, ALUSrcB=01, everything else 0).
- Outputs are Moore, decoded from registered state; the only Mealy terms are `IRWrite`/`PCWrite` in IF, gated by `mio_ready`.
- Latencies with zero wait: R/I/srl 4 cycles, lw 5, sw 4, branch/jump/lui 3.
- `rst` mid-access aborts immediately to IF; no memory strobe survives.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state codes;
  - opcode and funct constants;
  - ALU op codes;
  - PCSource/MemtoReg/RegDst/ALUSrcB select codes;
  - trap cause codes.
- Sub-module `mc_alu_decode` is purely combinational: (aluop class, `inst`) → `ALU_operation`.

## Test plan
- lw with `mio_ready` delayed 3 cycles in IF and 2 in MEM_RD → state sequence IF×4, ID, EX_MEM, MEM_RD×3, WB_LW; `RegWrite`=1 and MemtoReg=01 only in WB_LW.
- sw (opcode 101011) → EX_MEM then MEM_WR with `MemWrite`=1 and `IorD`=1, then IF.
- add, `overflow`=1 in EX_R, `OVF_TRAP`=1 → TRAP, `trap_cause`=01, `RegWrite` never asserted; `trap_clear` → IF. Same case with `OVF_TRAP`=0 → WB_R.
- `mio_ready` held 0 in IF, `TIMEOUT`=16 → TRAP after exactly 16 IF cycles, cause 10. With ready arriving on cycle 16 → ID instead.
- Opcode 111111 → TRAP, cause 11. beq with `zero`=1 → `PCWriteCond`=1, `Branch`=1, ALU op 110. jal → RegDst=10, MemtoReg=11, PCSource=10.
- Assert `rst` during MEM_WR wait → next observed state IF, `MemWrite`=0 asynchronously.
